// File: rtl/alu_pkg.sv
// Shared opcode encoding and helpers for the alu_pipe datapath.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    XOR = 3'd3,
    OR  = 3'd4,
    SLT = 3'd5,
    SLL = 3'd6,
    SRA = 3'd7
  } alu_op_e;

  // Width of the shift-amount field taken from the low bits of operand B.
  function automatic int unsigned shamt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, signed-overflow and zero flag from A, B and opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] res_c,
  output logic             ovf_c,
  output logic             zero_c
);

  localparam int unsigned SW = shamt_w(WIDTH);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SW-1:0]    shamt;
  logic             slt;

  assign sum   = a + b;
  assign diff  = a - b;
  assign shamt = b[SW-1:0];
  assign slt   = $signed(a) < $signed(b);

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (op)
      ADD: begin
        res_c = sum;
        ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        res_c = diff;
        ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      AND: res_c = a & b;
      XOR: res_c = a ^ b;
      OR:  res_c = a | b;
      SLT: res_c = {{(WIDTH-1){1'b0}}, slt};
      SLL: res_c = a << shamt;
      SRA: res_c = WIDTH'($signed(a) >>> shamt);
    endcase
    zero_c = (res_c == '0);
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake and full backpressure.
// Optional ALU_PIPE_STICKY_EN adds a sticky overflow flag (ovf_sticky / ovf_clr).
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             out_ovf,
`ifdef ALU_PIPE_STICKY_EN
  output logic             ovf_sticky,
  input  logic             ovf_clr,
`endif
  output logic             out_zero
);

  logic             adv;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  alu_op_e          s1_op;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             zero_c;

  // Both stages move together whenever the output slot is free or being drained.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1: operand capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= ADD;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= in_a;
        s1_b  <= in_b;
        s1_op <= alu_op_e'(in_op);
      end
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .res_c  (res_c),
    .ovf_c  (ovf_c),
    .zero_c (zero_c)
  );

  // S2: result capture; data only reloads on a real beat so bubbles leave it untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_c     <= '0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_c    <= res_c;
        out_ovf  <= ovf_c;
        out_zero <= zero_c;
      end
    end
  end

`ifdef ALU_PIPE_STICKY_EN
  // Set on delivery of an overflowing beat; set beats a same-edge clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && out_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end
`endif

endmodule
